// File: rtl/bb_ram_loader.sv
// bb_ram_loader: sync-hunting frame parser that writes payload words into one of 24 baseband RAMs and checks an XOR trailer.
module bb_ram_loader #(
  parameter logic [15:0] SYNC      = 16'hA55A,
  parameter int          CA_WORDS  = 32,
  parameter int          MSG_WORDS = 47,
  parameter int          CTL_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        hold,
  output logic [31:0] wr_data,
  output logic [5:0]  wr_addr,
  output logic [23:0] wren,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER, DROP} state_t;
  state_t      state, state_nx;
  logic [4:0]  tgt, tgt_nx;
  logic [5:0]  idx, idx_nx, len, len_nx;
  logic [31:0] acc, acc_nx, wr_data_nx;
  logic [5:0]  wr_addr_nx;
  logic [23:0] wren_nx;
  logic        ok_nx, err_nx, accept;
  logic [4:0]  hdr_tgt;
  assign s_ready = ~hold;
  assign accept  = s_valid & ~hold;
  assign busy    = state != IDLE;
  assign hdr_tgt = s_data[12:8];
  always_comb begin
    state_nx   = state;
    tgt_nx     = tgt;
    idx_nx     = idx;
    len_nx     = len;
    acc_nx     = acc;
    wr_data_nx = wr_data;
    wr_addr_nx = wr_addr;
    wren_nx    = '0;
    ok_nx      = 1'b0;
    err_nx     = 1'b0;
    case (state)
      IDLE: if (accept && s_data[31:16] == SYNC) begin
        tgt_nx   = hdr_tgt;
        idx_nx   = '0;
        acc_nx   = '0;
        len_nx   = hdr_tgt <= 5'd7 ? 6'(CA_WORDS) : hdr_tgt <= 5'd15 ? 6'(MSG_WORDS) : 6'(CTL_WORDS);
        state_nx = hdr_tgt > 5'd23 ? DROP : PAYLOAD;
      end
      PAYLOAD: if (accept) begin
        wr_data_nx = s_data;
        wr_addr_nx = idx;
        wren_nx    = 24'd1 << tgt;
        acc_nx     = acc ^ s_data;
        idx_nx     = idx + 6'd1;
        state_nx   = idx == len - 6'd1 ? TRAILER : PAYLOAD;
      end
      TRAILER: if (accept) begin
        ok_nx    = s_data == acc;
        err_nx   = s_data != acc;
        state_nx = IDLE;
      end
      DROP: begin
        err_nx   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tgt       <= '0;
      idx       <= '0;
      len       <= '0;
      acc       <= '0;
      wr_data   <= '0;
      wr_addr   <= '0;
      wren      <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nx;
      tgt       <= tgt_nx;
      idx       <= idx_nx;
      len       <= len_nx;
      acc       <= acc_nx;
      wr_data   <= wr_data_nx;
      wr_addr   <= wr_addr_nx;
      wren      <= wren_nx;
      frame_ok  <= ok_nx;
      frame_err <= err_nx;
      err_cnt   <= err_cnt + {7'd0, err_nx && err_cnt != 8'hFF};
    end
  end
endmodule

// File: tb/tb_bb_ram_loader.sv
// tb_bb_ram_loader: directed vector table plus frame-level sequences for bb_ram_loader.
module tb_bb_ram_loader;
  logic        clk, rst_n, s_valid, s_ready, hold;
  logic [31:0] s_data, wr_data;
  logic [5:0]  wr_addr;
  logic [23:0] wren;
  logic        frame_ok, frame_err, busy;
  logic [7:0]  err_cnt;
  int          tests = 0, fails = 0;
  logic [7:0]  exp_cnt = 0;

  bb_ram_loader dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .hold(hold), .wr_data(wr_data), .wr_addr(wr_addr), .wren(wren),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] d;
    logic        v, h;
    logic [23:0] w;
    logic [5:0]  a;
    logic [31:0] wd;
    logic        ok, er, bz;
    logic [7:0]  cnt;
  } vec_t;
  vec_t vec[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] d, input logic v, input logic h);
    s_data = d; s_valid = v; hold = h;
    @(posedge clk);
    #1;
  endtask

  // n payload words base+i; stall bit i%8 inserts one non-accept cycle before word i
  task automatic frame(input logic [4:0] t, input int n, input logic [23:0] ew,
                       input logic [31:0] base, input bit bad, input logic [7:0] stall);
    logic [31:0] x, w;
    x = 0;
    step({16'hA55A, 3'b000, t, 8'h00}, 1, 0);
    chk("hdr_busy", {31'd0, busy}, 1);
    chk("hdr_wren", {8'd0, wren}, 0);
    for (int i = 0; i < n; i++) begin
      if (stall[i % 8]) begin
        step(32'hA55A_0000, i % 2 == 0, i % 2 == 0);
        chk("stall_wren", {8'd0, wren}, 0);
        chk("stall_ready", {31'd0, s_ready}, {31'd0, ~hold});
      end
      w = base + 32'(i);
      x ^= w;
      step(w, 1, 0);
      chk("pl_wren", {8'd0, wren}, {8'd0, ew});
      chk("pl_addr", {26'd0, wr_addr}, 32'(i));
      chk("pl_data", wr_data, w);
    end
    if (bad && exp_cnt != 8'hFF) exp_cnt++;
    step(bad ? x ^ 32'd1 : x, 1, 0);
    chk("tr_ok", {31'd0, frame_ok}, {31'd0, !bad});
    chk("tr_err", {31'd0, frame_err}, {31'd0, bad});
    chk("tr_cnt", {24'd0, err_cnt}, {24'd0, exp_cnt});
    chk("tr_busy", {31'd0, busy}, 0);
    chk("tr_wren", {8'd0, wren}, 0);
  endtask

  initial begin
    vec[0]  = '{32'hDEAD_BEEF, 1, 0, 24'h0,      6'd0, 32'h0,  0, 0, 0, 8'd0};
    vec[1]  = '{32'hA55A_1000, 1, 0, 24'h0,      6'd0, 32'h0,  0, 0, 1, 8'd0};
    vec[2]  = '{32'h0000_0011, 1, 0, 24'h010000, 6'd0, 32'h11, 0, 0, 1, 8'd0};
    vec[3]  = '{32'h0000_0022, 0, 0, 24'h0,      6'd0, 32'h0,  0, 0, 1, 8'd0};
    vec[4]  = '{32'h0000_0022, 1, 0, 24'h010000, 6'd1, 32'h22, 0, 0, 1, 8'd0};
    vec[5]  = '{32'h0000_0044, 1, 0, 24'h010000, 6'd2, 32'h44, 0, 0, 1, 8'd0};
    vec[6]  = '{32'h0000_0088, 1, 0, 24'h010000, 6'd3, 32'h88, 0, 0, 1, 8'd0};
    vec[7]  = '{32'h0000_00FF, 1, 0, 24'h0,      6'd0, 32'h0,  1, 0, 0, 8'd0};
    vec[8]  = '{32'hA55A_1F00, 1, 0, 24'h0,      6'd0, 32'h0,  0, 0, 1, 8'd0};
    vec[9]  = '{32'hDEAD_BEEF, 0, 0, 24'h0,      6'd0, 32'h0,  0, 1, 0, 8'd1};
    vec[10] = '{32'h0000_0000, 0, 0, 24'h0,      6'd0, 32'h0,  0, 0, 0, 8'd1};

    rst_n = 0; s_data = 0; s_valid = 0; hold = 0;
    @(posedge clk); #1;
    chk("rst_wren", {8'd0, wren}, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_addr", {26'd0, wr_addr}, 0);
    chk("rst_pulses", {30'd0, frame_ok, frame_err}, 0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, s_ready}, 1);
    hold = 1; #1;
    chk("ready_hold", {31'd0, s_ready}, 0);
    hold = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      step(vec[i].d, vec[i].v, vec[i].h);
      chk($sformatf("vec%0d_wren", i), {8'd0, wren}, {8'd0, vec[i].w});
      if (vec[i].w != 0) begin
        chk($sformatf("vec%0d_addr", i), {26'd0, wr_addr}, {26'd0, vec[i].a});
        chk($sformatf("vec%0d_data", i), wr_data, vec[i].wd);
      end
      chk($sformatf("vec%0d_ok", i), {31'd0, frame_ok}, {31'd0, vec[i].ok});
      chk($sformatf("vec%0d_err", i), {31'd0, frame_err}, {31'd0, vec[i].er});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vec[i].bz});
      chk($sformatf("vec%0d_cnt", i), {24'd0, err_cnt}, {24'd0, vec[i].cnt});
    end
    exp_cnt = 1;

    frame(5'd3, 32, 24'h000008, 32'h1000_0000, 0, 8'h00);
    frame(5'd12, 47, 24'h001000, 32'h2000_0000, 1, 8'h00);

    for (int i = 0; i < 3; i++) begin
      step(32'hDEAD_BEEF, 1, 0);
      chk("junk_wren", {8'd0, wren}, 0);
      chk("junk_busy", {31'd0, busy}, 0);
    end
    step(32'hA55A_1F00, 1, 0);
    chk("drop_busy", {31'd0, busy}, 1);
    chk("drop_wren", {8'd0, wren}, 0);
    step(32'h0, 0, 0);
    exp_cnt++;
    chk("drop_err", {31'd0, frame_err}, 1);
    chk("drop_busy_lo", {31'd0, busy}, 0);
    chk("drop_cnt", {24'd0, err_cnt}, {24'd0, exp_cnt});
    step(32'h0, 0, 0);
    chk("drop_err_lo", {31'd0, frame_err}, 0);

    frame(5'd20, 4, 24'h100000, 32'h3000_0000, 0, 8'b1011_0101);

    step(32'hA55A_0300, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(32'h4000_0000 + 32'(i), 1, 0);
      chk("pre_rst_addr", {26'd0, wr_addr}, 32'(i));
    end
    rst_n = 0; #1;
    chk("mid_rst_wren", {8'd0, wren}, 0);
    chk("mid_rst_data", wr_data, 0);
    chk("mid_rst_addr", {26'd0, wr_addr}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_cnt", {24'd0, err_cnt}, 0);
    exp_cnt = 0;
    @(negedge clk); rst_n = 1;
    step(32'h0, 0, 0);
    chk("post_rst_pulse", {30'd0, frame_ok, frame_err}, 0);
    frame(5'd3, 32, 24'h000008, 32'h1000_0000, 0, 8'h00);

    for (int k = 0; k < 260; k++)
      frame(5'd16 + 5'(k % 8), 4, 24'h010000 << (k % 8), 32'(k) << 8, 1, 8'h00);
    chk("sat_cnt", {24'd0, err_cnt}, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bb_ram_loader.md
# bb_ram_loader

Frame parser and write sequencer that feeds the baseband code/message RAMs from the USB3 32-bit receive stream. It hunts for a sync header, decodes the target RAM index, and emits one write per payload word with a one-hot 24-bit write enable and an explicit word address. It then checks an XOR trailer and reports the frame result. It sits between the FX3 slave-FIFO receive logic (upstream) and the per-channel CA/message/control RAM bank (downstream).

## Interface
- SYNC, 16'hA55A, header sync pattern in header bits [31:16]
- CA_WORDS, 32, payload length for targets 0-7 (CA code RAMs, 1024 bits)
- MSG_WORDS, 47, payload length for targets 8-15 (message RAMs, 1504 bits)
- CTL_WORDS, 4, payload length for targets 16-23 (control words)

- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  32  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  block accepts the word; equals ~hold
- hold  in  1  downstream back-pressure; deasserts s_ready
- wr_data  out  32  RAM write data, registered
- wr_addr  out  6  RAM word address, registered
- wren  out  24  one-hot write enable: bit n writes target n
- frame_ok  out  1  one-cycle pulse: frame trailer matched
- frame_err  out  1  one-cycle pulse: bad target or checksum mismatch
- err_cnt  out  8  saturating count of frame_err pulses
- busy  out  1  high in every state except IDLE

## Operation
- Accept occurs when s_valid & s_ready on a rising edge. No state changes without an accept, except the output pulses clearing.
- The FSM has four states: IDLE, PAYLOAD, TRAILER, DROP. DROP is transient and is used only for a bad target.
- IDLE: discard accepted words until s_data[31:16]==SYNC. Then latch tgt=s_data[12:8], set len from tgt, clear word index idx and the XOR accumulator.
  - tgt<=7 gives len=CA_WORDS; 8-15 gives MSG_WORDS; 16-23 gives CTL_WORDS.
  - tgt>23 goes to DROP. Bits [15:13] and [7:0] are ignored.
- PAYLOAD: each accepted word does three things:
  - Registers wr_data=word, wr_addr=idx, wren=1<<tgt.
  - Updates acc ^= word.
  - Increments idx. When idx==len-1 on accept, go to TRAILER.
- TRAILER: the next accepted word is compared against acc. Equal gives a frame_ok pulse; unequal gives a frame_err pulse. Both return to IDLE.
- DROP: pulse frame_err on the next cycle, then go to IDLE with no accept required. No writes occur.
- Writes are committed as they arrive. A checksum error does not roll back RAM contents; it only flags the frame.
- err_cnt increments on every frame_err and saturates at 8'hFF.
- wren is zero in every cycle without a PAYLOAD accept. Exactly one bit is set when it is nonzero.
- Width rules:
  - idx is 6 bits; len is at most 47, so it never overflows.
  - wr_addr for targets 0-7 covers 0..31, for 8-15 covers 0..46, for 16-23 covers 0..3.

## Timing
- Reset values: s_ready=~hold (combinational), wr_data=0, wr_addr=0, wren=0, frame_ok=0, frame_err=0, err_cnt=0, busy=0, FSM=IDLE, idx=0, acc=0.
- Write latency: a payload word accepted at edge k appears on wr_data/wr_addr/wren after edge k+1, for one cycle.
- Result latency:
  - frame_ok/frame_err are high for exactly the cycle after the trailer accept edge.
  - For DROP, frame_err is high for the cycle after the cycle following the header accept.
- Throughput is one word per clock. A header accepted on the cycle immediately after a trailer is valid and starts a new frame.
- A SYNC-pattern word inside PAYLOAD or TRAILER is treated as data; there is no resynchronisation mid-frame.
- With hold=1 or s_valid=0 mid-frame, the FSM, idx and acc are held and wren is 0. The frame resumes on the next accept.
- An rst_n assertion mid-frame:
  - Immediately forces every output except s_ready to its reset value.
  - Sends the FSM to IDLE.
  - Abandons the partial frame: no frame_ok/frame_err pulse and no err_cnt change.

## Test plan
- CA frame: header 32'hA55A_0300 then 32 words 32'h1000_0000+i, trailer = XOR of those words. Required response:
  - 32 cycles of wren=24'h000008, wr_addr 0..31, matching wr_data.
  - frame_ok pulse one cycle after the trailer; err_cnt=0.
- MSG frame: target 12 with 47 words and a wrong trailer (correct XOR ^1). Required response: wren=24'h001000 for 47 writes, wr_addr 0..46, then a frame_err pulse and err_cnt=1.
- Bad target and junk: idle junk words 32'hDEAD_BEEF, then header 32'hA55A_1F00. Required response: no wren, busy high then low, a frame_err pulse, err_cnt increments.
- Back-pressure: CTL frame to target 20 with s_valid and hold toggled pseudo-randomly. Required response: exactly 4 writes (wren=24'h100000, addr 0..3) in order, then frame_ok.
- Reset mid-frame: rst_n pulsed low after the 10th payload word of a CA frame, then a full valid frame sent. Required response:
  - Outputs are zero immediately on reset and no pulse is emitted for the abandoned frame.
  - The second frame writes addr 0..31 and gives frame_ok.
- Back-to-back and saturation: 260 consecutive checksum-bad CTL frames with no idle cycles. Required response: 260 frame_err pulses, err_cnt saturates at 8'hFF, full one-word-per-clock throughput.
